// File: rtl/proteus_nbout_packer.sv
// Packs Tn neuron outputs per beat, each reduced to n bits, LSB-first into dense N*Tn-bit words.
// Define PROTEUS_PACK_SAT_EN to saturate each value to the signed n-bit range instead of truncating.
module proteus_nbout_packer #(
    parameter int N          = 16,
    parameter int Tn         = 16,
    parameter int SHIFT_BITS = 5,
    parameter int FILL_W     = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cfg_load,
    input  logic [SHIFT_BITS-2:0] i_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [N*Tn-1:0]       i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [N*Tn-1:0]       o_data,
    output logic                  o_last
);
    localparam int W     = N * Tn;
    localparam int BUF_W = 2 * W - 1;
    localparam int CNT_W = FILL_W + 1;

    typedef enum logic {ST_ACC, ST_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [SHIFT_BITS-2:0] r_ncode;
    logic [FILL_W-1:0]     r_fill;
    logic [BUF_W-1:0]      r_buf;
    logic [W-1:0]          r_data;
    logic                  r_valid, r_last;

    logic                  w_free, w_accept, w_emit, w_drain_load;
    logic [SHIFT_BITS-1:0] w_n;
    logic [N-1:0]          w_mask, w_val;
    logic [W-1:0]          w_beat;
    logic [BUF_W-1:0]      w_merged;
    logic [CNT_W-1:0]      w_count, w_rem;

`ifdef PROTEUS_PACK_SAT_EN
    function automatic logic [N-1:0] sat_value(input logic [N-1:0] v, input logic [SHIFT_BITS-1:0] n);
        logic [N:0]        pow;
        logic signed [N:0] sv, smax, smin;
        pow  = (N+1)'(1) << (n - SHIFT_BITS'(1));
        sv   = $signed({v[N-1], v});
        smax = $signed(pow - (N+1)'(1));
        smin = -$signed(pow);
        if (sv > smax)      sat_value = smax[N-1:0];
        else if (sv < smin) sat_value = smin[N-1:0];
        else                sat_value = v;
    endfunction
`endif

    assign w_n          = SHIFT_BITS'(r_ncode) + SHIFT_BITS'(1);
    assign w_mask       = (N'(1) << w_n) - N'(1);
    assign w_free       = !r_valid || i_ready;
    assign o_ready      = (r_state == ST_ACC) && w_free;
    assign w_accept     = i_valid && o_ready;
    assign w_drain_load = (r_state == ST_DRAIN) && w_free;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_beat = '0;
        w_val  = '0;
        for (int k = 0; k < Tn; k++) begin
            w_val = i_data[k*N +: N];
`ifdef PROTEUS_PACK_SAT_EN
            w_val = sat_value(w_val, w_n);
`endif
            w_beat = w_beat | (W'(w_val & w_mask) << (k * int'(w_n)));
        end
    end

    // The new beat lands directly above the current residue; a full word is always in the low W bits.
    assign w_merged = r_buf | (BUF_W'(w_beat) << r_fill);
    assign w_count  = CNT_W'(r_fill) + CNT_W'(Tn) * CNT_W'(w_n);
    assign w_emit   = w_count >= CNT_W'(W);
    assign w_rem    = w_emit ? w_count - CNT_W'(W) : w_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:   if (w_accept && i_last && (w_rem != '0)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_free) w_state_nxt = ST_ACC;
            default:  w_state_nxt = ST_ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACC;
        else        r_state <= w_state_nxt;
    end

    // NOTE: the residue buffer is reset because stale bits above fill would be OR-merged into later words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ncode <= (SHIFT_BITS-1)'(N - 1);
            r_fill  <= '0;
            r_buf   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_free) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if (w_accept) begin
                if (w_emit) begin
                    r_data  <= w_merged[W-1:0];
                    r_valid <= 1'b1;
                    r_last  <= i_last && (w_rem == '0);
                    r_buf   <= w_merged >> W;
                end else begin
                    r_buf   <= w_merged;
                end
                r_fill <= w_rem[FILL_W-1:0];
            end else if (w_drain_load) begin
                r_data  <= r_buf[W-1:0];
                r_valid <= 1'b1;
                r_last  <= 1'b1;
                r_buf   <= '0;
                r_fill  <= '0;
            end
            // A beat in the same cycle still packs with the old precision.
            if (i_cfg_load && (r_state == ST_ACC) && (r_fill == '0)) r_ncode <= i_n;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: tb/tb_proteus_nbout_packer.sv
// Directed bench for proteus_nbout_packer with a bit-level packing model feeding an expected-word queue.
// Honours PROTEUS_PACK_SAT_EN so expectations track the build being simulated.
module tb_proteus_nbout_packer;
    localparam int N  = 16;
    localparam int TN = 16;
    localparam int W  = N * TN;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_cfg_load;
    logic [3:0]   i_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data;
    logic         i_last;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic         o_last;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_words  = 0;
    word_t        exp_q[$];

    logic [1023:0] m_bits;
    int            m_fill;
    int            m_n;

    proteus_nbout_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cfg_load (i_cfg_load),
        .i_n        (i_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_last     (o_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] reduce(input logic [15:0] v);
`ifdef PROTEUS_PACK_SAT_EN
        int sv, hi, lo;
        sv = int'($signed(v));
        hi = (1 << (m_n - 1)) - 1;
        lo = -(1 << (m_n - 1));
        if (sv > hi) sv = hi;
        if (sv < lo) sv = lo;
        return sv[15:0];
`else
        return v;
`endif
    endfunction

    task automatic model_beat(input logic [W-1:0] d, input logic last);
        logic [15:0] r;
        for (int k = 0; k < TN; k++) begin
            r = reduce(d[k*N +: N]);
            for (int b = 0; b < m_n; b++) begin
                m_bits[m_fill] = r[b];
                m_fill++;
            end
        end
        if (m_fill >= W) begin
            exp_q.push_back({m_bits[W-1:0], last && (m_fill == W)});
            m_bits = m_bits >> W;
            m_fill -= W;
        end
        if (last && m_fill != 0) begin
            exp_q.push_back({m_bits[W-1:0], 1'b1});
            m_bits = '0;
            m_fill = 0;
        end
    endtask

    // Scoreboard: every handshaked word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            word_t e;
            n_words++;
            if (exp_q.size() == 0) begin
                check("word_unexpected", W'(exp_q.size()), W'(1));
            end else begin
                e = exp_q.pop_front();
                check("word_data", o_data, e.data);
                check("word_last", W'(o_last), W'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int c);
        i_cfg_load = 1'b1;
        i_n        = 4'(c);
        step();
        i_cfg_load = 1'b0;
        m_n        = c + 1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        bit acc = 0;
        int budget = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        while (!acc && budget < 50) begin
            @(negedge clk);
            if (o_ready) begin
                acc = 1;
                model_beat(d, last);
            end
            @(posedge clk);
            #1;
            budget++;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (!acc) check("beat_accept_timeout", W'(acc), W'(1));
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [W-1:0] d, x, y, e;
        int           w0;
        int           fills [4] = '{192, 128, 64, 0};

        rst_n = 1'b0; i_cfg_load = 1'b0; i_n = '0; i_valid = 1'b0;
        i_data = '0; i_last = 1'b0; i_ready = 1'b1;
        m_bits = '0; m_fill = 0; m_n = 16;
        #12;
        check("rst_o_valid", W'(o_valid), W'(0));
        check("rst_o_data", o_data, '0);
        check("rst_o_last", W'(o_last), W'(0));
        check("rst_fill", W'(dut.r_fill), W'(0));
        check("rst_n_passthru", W'(dut.r_ncode), W'(15));
        step();
        rst_n = 1'b1;
        step();

        // 1: n=16 pass-through, back-to-back, 1-cycle latency
        cfg(15);
        for (int i = 0; i < 4; i++) begin
            d = rand_word();
            send_beat(d, 1'b0);
            check("t1_valid", W'(o_valid), W'(1));
            check("t1_data", o_data, d);
        end

        // 2: n=8, two beats form one word of bytes 0..31
        cfg(7);
        for (int k = 0; k < TN; k++) d[k*N +: N] = 16'(k);
        send_beat(d, 1'b0);
        check("t2_no_word_after_a", W'(o_valid), W'(0));
        for (int k = 0; k < TN; k++) d[k*N +: N] = 16'(k + 16);
        send_beat(d, 1'b0);
        for (int j = 0; j < 32; j++) e[j*8 +: 8] = 8'(j);
        check("t2_valid", W'(o_valid), W'(1));
        check("t2_data", o_data, e);

        // 3: n=12, words straddle beats
        cfg(11);
        w0 = n_words;
        for (int i = 0; i < 4; i++) begin
            send_beat(rand_word(), 1'b0);
            check("t3_fill", W'(dut.r_fill), W'(fills[i]));
            check("t3_valid", W'(o_valid), W'(i > 0));
        end
        step();
        step();
        check("t3_word_count", W'(n_words - w0), W'(3));

        // 4: single short beat with i_last drains a zero-padded word
        cfg(7);
        for (int k = 0; k < TN; k++) d[k*N +: N] = 16'h00AB;
        send_beat(d, 1'b1);
        check("t4_drain_ready", W'(o_ready), W'(0));
        step();
        check("t4_valid", W'(o_valid), W'(1));
        check("t4_last", W'(o_last), W'(1));
`ifdef PROTEUS_PACK_SAT_EN
        e = {128'h0, {16{8'h7F}}};
`else
        e = {128'h0, {16{8'hAB}}};
`endif
        check("t4_data", o_data, e);
        step();

        // 5: downstream stall holds the word and blocks further beats
        cfg(15);
        i_ready = 1'b0;
        x = rand_word();
        y = rand_word();
        send_beat(x, 1'b0);
        i_valid = 1'b1;
        i_data  = y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", W'(o_valid), W'(1));
            check("t5_hold_data", o_data, x);
            check("t5_hold_ready", W'(o_ready), W'(0));
        end
        step();
        i_ready = 1'b1;
        send_beat(y, 1'b0);
        check("t5_second_word", o_data, y);
        step();

        // 6: saturation versus truncation at n=4
        cfg(3);
        d = '0;
        d[15:0]  = 16'h0009;
        d[31:16] = 16'hFFF0;
        send_beat(d, 1'b1);
        step();
        check("t6_last", W'(o_last), W'(1));
`ifdef PROTEUS_PACK_SAT_EN
        check("t6_packed", W'(o_data[7:0]), W'(8'h87));
`else
        check("t6_packed", W'(o_data[7:0]), W'(8'h09));
`endif
        step();

        // Reset asserted while in DRAIN
        cfg(7);
        send_beat(rand_word(), 1'b1);
        check("rd_in_drain", W'(o_ready), W'(0));
        rst_n = 1'b0;
        exp_q.delete();
        m_bits = '0; m_fill = 0; m_n = 16;
        #1;
        check("rd_o_valid", W'(o_valid), W'(0));
        check("rd_o_last", W'(o_last), W'(0));
        check("rd_fill", W'(dut.r_fill), W'(0));
        step();
        rst_n = 1'b1;
        step();
        d = rand_word();
        send_beat(d, 1'b0);
        check("rd_passthru_after", o_data, d);

        step();
        step();
        check("queue_drained", W'(exp_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
